// File: rtl/write_port_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among several write-domain producers.
// Each grant lasts one burst (up to max_burst beats, or until req_last); write_full stalls the owner in place.
module write_port_arbiter #(
  parameter int requesters = 4,
  parameter int data_width = 8,
  parameter int max_burst  = 4
) (
  input  logic                             write_clk,
  input  logic                             write_rst,
  input  logic [requesters-1:0]            req_valid,
  input  logic [requesters-1:0]            req_last,
  input  logic [requesters*data_width-1:0] req_data,
  output logic [requesters-1:0]            req_ready,
  input  logic                             write_full,
  output logic                             write_inc,
  output logic [data_width-1:0]            write_data,
  output logic [requesters-1:0]            grant,
  output logic                             busy
);

  localparam int PW = (requesters > 1) ? $clog2(requesters) : 1;
  localparam int BW = $clog2(max_burst) + 1;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t                state_q, state_d;
  logic [requesters-1:0] grant_q, grant_d;
  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]         beat_q, beat_d;

  logic [PW-1:0]         owner;
  logic [PW-1:0]         pick_idx;
  logic                  pick_found;
  logic [data_width-1:0] data_arr [requesters];

  for (genvar gi = 0; gi < requesters; gi++) begin : g_unpack
    assign data_arr[gi] = req_data[gi*data_width +: data_width];
  end

  // Binary index of the one-hot grant.
  always_comb begin
    owner = '0;
    for (int i = 0; i < requesters; i++) begin
      if (grant_q[i]) begin
        owner = PW'(i);
      end
    end
  end

  // Rotating priority search: scanning offsets downward lets the smallest offset from rr_ptr win.
  always_comb begin
    logic [PW:0] sum;
    pick_found = 1'b0;
    pick_idx   = '0;
    sum        = '0;
    for (int k = requesters - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (sum >= (PW+1)'(requesters)) begin
        sum = sum - (PW+1)'(requesters);
      end
      if (req_valid[sum[PW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = sum[PW-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_d     = beat_q;
    write_inc  = 1'b0;
    req_ready  = '0;
    write_data = '0;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          beat_d            = '0;
          state_d           = BURST;
        end
      end

      BURST: begin
        write_data = data_arr[owner];
        write_inc  = req_valid[owner] & ~write_full;
        req_ready  = grant_q & {requesters{~write_full}};
        if (write_inc) begin
          beat_d = beat_q + BW'(1);
          // beat_q counts beats already written, so max_burst-1 marks the final allowed beat.
          if (req_last[owner] || (beat_q == BW'(max_burst - 1))) begin
            state_d  = IDLE;
            grant_d  = '0;
            beat_d   = '0;
            rr_ptr_d = (owner == PW'(requesters - 1)) ? '0 : owner + PW'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge write_clk or posedge write_rst) begin
    if (write_rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      beat_q   <= beat_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q == BURST);

endmodule
